// File: rtl/ring_meas_sequencer.sv
// ring_meas_sequencer
// Autonomous controller for the ring-oscillator speed-test macro: arms both rings,
// fires the trigger, waits for the fired flag, powers the rings down, reads back the
// six count bytes through the select mux and publishes counts, ticks and error flags.
module ring_meas_sequencer #(
    parameter int unsigned TRIG_CYCLES   = 2,
    parameter int unsigned SETTLE_CYCLES = 3,
    parameter int unsigned FIRE_TIMEOUT  = 16,
    parameter int unsigned MIN_COUNT     = 10,
    parameter int unsigned MAX_DELTA     = 3
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  meas_in,
    output logic [1:0]  ring_en,
    output logic [2:0]  sel,
    output logic        trig,
    output logic        busy,
    output logic        done,
    output logic [23:0] count0,
    output logic [23:0] count1,
    output logic [23:0] ticks0,
    output logic [23:0] ticks1,
    output logic        err_small,
    output logic        err_mismatch,
    output logic        err_ovf,
    output logic        err_timeout,
    output logic        err_stale
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_TRIG,
        S_SETTLE,
        S_WAIT_FIRE,
        S_READ,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [7:0]  TRIG_LAST   = 8'(TRIG_CYCLES - 1);
    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0]  FIRE_LAST   = 8'(FIRE_TIMEOUT - 1);
    localparam logic [23:0] MIN_C       = 24'(MIN_COUNT);
    localparam logic [23:0] MAX_D       = 24'(MAX_DELTA);

    state_t      state;
    logic [7:0]  cyc_cnt;
    logic [2:0]  byte_idx;
    logic        read_phase;
    logic [47:0] shadow;

    logic [23:0] raw0;
    logic [23:0] raw1;
    logic [23:0] delta;

    // Assemble the freshly read counts and their unsigned absolute difference.
    always_comb begin
        raw0 = shadow[23:0];
        raw1 = shadow[47:24];
        if (raw0 >= raw1) begin
            delta = raw0 - raw1;
        end else begin
            delta = raw1 - raw0;
        end
    end

    // Measurement sequencer; every output is a register updated on the transition
    // into the state that owns it.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state        <= S_IDLE;
            cyc_cnt      <= '0;
            byte_idx     <= '0;
            read_phase   <= 1'b0;
            shadow       <= '0;
            ring_en      <= '0;
            sel          <= '0;
            trig         <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            count0       <= '0;
            count1       <= '0;
            ticks0       <= '0;
            ticks1       <= '0;
            err_small    <= 1'b0;
            err_mismatch <= 1'b0;
            err_ovf      <= 1'b0;
            err_timeout  <= 1'b0;
            err_stale    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort && (state != S_IDLE)) begin
                // Partially read bytes stay in shadow only; published counts are untouched.
                state   <= S_IDLE;
                ring_en <= '0;
                sel     <= '0;
                trig    <= 1'b0;
                busy    <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            state        <= S_ARM;
                            busy         <= 1'b1;
                            ring_en      <= 2'b11;
                            sel          <= '0;
                            err_small    <= 1'b0;
                            err_mismatch <= 1'b0;
                            err_ovf      <= 1'b0;
                            err_timeout  <= 1'b0;
                            err_stale    <= 1'b0;
                        end
                    end
                    S_ARM: begin
                        if (meas_in[6]) begin
                            err_stale <= 1'b1;
                            ring_en   <= '0;
                            done      <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            trig    <= 1'b1;
                            cyc_cnt <= '0;
                            state   <= S_TRIG;
                        end
                    end
                    S_TRIG: begin
                        if (cyc_cnt == TRIG_LAST) begin
                            trig    <= 1'b0;
                            cyc_cnt <= '0;
                            state   <= S_SETTLE;
                        end else begin
                            cyc_cnt <= cyc_cnt + 8'd1;
                        end
                    end
                    S_SETTLE: begin
                        if (cyc_cnt == SETTLE_LAST) begin
                            ring_en <= '0;
                            sel     <= 3'b111;
                            cyc_cnt <= '0;
                            state   <= S_WAIT_FIRE;
                        end else begin
                            cyc_cnt <= cyc_cnt + 8'd1;
                        end
                    end
                    S_WAIT_FIRE: begin
                        if (meas_in[6]) begin
                            sel        <= 3'd1;
                            byte_idx   <= 3'd1;
                            read_phase <= 1'b0;
                            state      <= S_READ;
                        end else if (cyc_cnt == FIRE_LAST) begin
                            err_timeout <= 1'b1;
                            sel         <= '0;
                            done        <= 1'b1;
                            state       <= S_DONE;
                        end else begin
                            cyc_cnt <= cyc_cnt + 8'd1;
                        end
                    end
                    S_READ: begin
                        // Bytes shift in from the top so byte 1 ends at [7:0] and byte 6 at [47:40].
                        if (!read_phase) begin
                            read_phase <= 1'b1;
                        end else begin
                            read_phase <= 1'b0;
                            shadow     <= {meas_in, shadow[47:8]};
                            if (byte_idx == 3'd6) begin
                                sel   <= '0;
                                state <= S_CHECK;
                            end else begin
                                byte_idx <= byte_idx + 3'd1;
                                sel      <= byte_idx + 3'd1;
                            end
                        end
                    end
                    S_CHECK: begin
                        count0       <= raw0;
                        count1       <= raw1;
                        ticks0       <= 24'hFFFFFF - raw0;
                        ticks1       <= 24'hFFFFFF - raw1;
                        err_small    <= (raw0 < MIN_C) || (raw1 < MIN_C);
                        err_mismatch <= (delta > MAX_D);
                        err_ovf      <= !raw0[23] || !raw1[23];
                        done         <= 1'b1;
                        state        <= S_DONE;
                    end
                    S_DONE: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ring_meas_sequencer.sv
// Testbench for ring_meas_sequencer: behavioural speed-test macro model, table of
// measurement vectors checked through a scoreboard queue, plus hand-written sequences
// for stale flag, abort, ignored restart and asynchronous reset.
module tb_ring_meas_sequencer;

    logic        clk;
    logic        nrst;
    logic        start;
    logic        abort;
    logic [7:0]  meas_in;
    logic [1:0]  ring_en;
    logic [2:0]  sel;
    logic        trig;
    logic        busy;
    logic        done;
    logic [23:0] count0;
    logic [23:0] count1;
    logic [23:0] ticks0;
    logic [23:0] ticks1;
    logic        err_small;
    logic        err_mismatch;
    logic        err_ovf;
    logic        err_timeout;
    logic        err_stale;

    ring_meas_sequencer #(
        .TRIG_CYCLES  (2),
        .SETTLE_CYCLES(3),
        .FIRE_TIMEOUT (16),
        .MIN_COUNT    (10),
        .MAX_DELTA    (3)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .start       (start),
        .abort       (abort),
        .meas_in     (meas_in),
        .ring_en     (ring_en),
        .sel         (sel),
        .trig        (trig),
        .busy        (busy),
        .done        (done),
        .count0      (count0),
        .count1      (count1),
        .ticks0      (ticks0),
        .ticks1      (ticks1),
        .err_small   (err_small),
        .err_mismatch(err_mismatch),
        .err_ovf     (err_ovf),
        .err_timeout (err_timeout),
        .err_stale   (err_stale)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Speed-test macro model
    logic [23:0] m_c0;
    logic [23:0] m_c1;
    int          fire_delay;
    logic        fire_en;
    logic        force_fired;
    logic        m_seen;
    int          m_since;
    logic        fired_m;

    always @(posedge clk) begin
        if (!busy) begin
            m_seen  <= 1'b0;
            m_since <= 0;
        end else if (trig) begin
            m_seen  <= 1'b1;
            m_since <= 0;
        end else if (m_seen && m_since < 255) begin
            m_since <= m_since + 1;
        end
    end

    always_comb begin
        fired_m = force_fired | (fire_en & m_seen & (m_since >= fire_delay));
        case (sel)
            3'd1:    meas_in = m_c0[7:0];
            3'd2:    meas_in = m_c0[15:8];
            3'd3:    meas_in = m_c0[23:16];
            3'd4:    meas_in = m_c1[7:0];
            3'd5:    meas_in = m_c1[15:8];
            3'd6:    meas_in = m_c1[23:16];
            default: meas_in = {1'b0, fired_m, 6'b0};
        endcase
    end

    // Pulse monitors
    int done_cnt = 0;
    int trig_cnt = 0;
    always @(posedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (trig) trig_cnt <= trig_cnt + 1;
    end

    typedef struct {
        logic [23:0] c0;
        logic [23:0] c1;
        logic [23:0] t0;
        logic [23:0] t1;
        logic [4:0]  flags;   // {small, mismatch, ovf, timeout, stale}
        int          lat;
        int          trigs;
    } exp_t;

    typedef struct {
        logic [23:0] c0;
        logic [23:0] c1;
        int          delay;
        logic        en;
        int          lat;
        logic [23:0] ec0;
        logic [23:0] ec1;
        logic [23:0] et0;
        logic [23:0] et1;
        logic [4:0]  flags;
    } vec_t;

    localparam int NV = 15;
    vec_t tbl [NV];
    exp_t sb [$];

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] flags_now();
        return {err_small, err_mismatch, err_ovf, err_timeout, err_stale};
    endfunction

    task automatic run_meas(input exp_t e, input int restart_at);
        int   n;
        bit   got;
        int   tc0;
        exp_t x;
        tc0 = trig_cnt;
        @(negedge clk);
        start = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        n     = 0;
        got   = 1'b0;
        while (!got && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            start = (restart_at != 0 && n == restart_at);
            if (done) got = 1'b1;
        end
        start = 1'b0;
        x = sb.pop_front();
        if (!got) begin
            chk("done_seen", 32'd0, 32'd1);
        end else begin
            chk("latency", n, x.lat);
            chk("count0", count0, x.c0);
            chk("count1", count1, x.c1);
            chk("ticks0", ticks0, x.t0);
            chk("ticks1", ticks1, x.t1);
            chk("flags", flags_now(), x.flags);
            chk("ring_en_at_done", ring_en, 2'b00);
            chk("trig_cycles", trig_cnt - tc0, x.trigs);
            @(posedge clk);
            #1;
            chk("done_one_cycle", done, 1'b0);
            chk("busy_after_done", busy, 1'b0);
        end
    endtask

    initial begin
        exp_t e;
        int   dc0;

        start = 0; abort = 0; nrst = 0;
        m_c0 = '0; m_c1 = '0; fire_delay = 0; fire_en = 0; force_fired = 0;

        tbl[0]  = '{24'hFFFF00, 24'hFFFF02, 3,  1'b1, 20, 24'hFFFF00, 24'hFFFF02, 24'h0000FF, 24'h0000FD, 5'b00000};
        tbl[1]  = '{24'hFFFF00, 24'hFFFF10, 2,  1'b1, 20, 24'hFFFF00, 24'hFFFF10, 24'h0000FF, 24'h0000EF, 5'b01000};
        tbl[2]  = '{24'hFFFF00, 24'h7FFFFF, 2,  1'b1, 20, 24'hFFFF00, 24'h7FFFFF, 24'h0000FF, 24'h800000, 5'b01100};
        tbl[3]  = '{24'h000005, 24'h000005, 2,  1'b1, 20, 24'h000005, 24'h000005, 24'hFFFFFA, 24'hFFFFFA, 5'b10100};
        tbl[4]  = '{24'h00000A, 24'h00000A, 2,  1'b1, 20, 24'h00000A, 24'h00000A, 24'hFFFFF5, 24'hFFFFF5, 5'b00100};
        tbl[5]  = '{24'h00000A, 24'h000009, 2,  1'b1, 20, 24'h00000A, 24'h000009, 24'hFFFFF5, 24'hFFFFF6, 5'b10100};
        tbl[6]  = '{24'hFFFF00, 24'hFFFF03, 2,  1'b1, 20, 24'hFFFF00, 24'hFFFF03, 24'h0000FF, 24'h0000FC, 5'b00000};
        tbl[7]  = '{24'hFFFF04, 24'hFFFF00, 2,  1'b1, 20, 24'hFFFF04, 24'hFFFF00, 24'h0000FB, 24'h0000FF, 5'b01000};
        tbl[8]  = '{24'h800000, 24'h800000, 2,  1'b1, 20, 24'h800000, 24'h800000, 24'h7FFFFF, 24'h7FFFFF, 5'b00000};
        tbl[9]  = '{24'hFFFFFF, 24'hFFFFFF, 2,  1'b1, 20, 24'hFFFFFF, 24'hFFFFFF, 24'h000000, 24'h000000, 5'b00000};
        tbl[10] = '{24'hA0B0C0, 24'hA0B0C2, 2,  1'b1, 20, 24'hA0B0C0, 24'hA0B0C2, 24'h5F4F3F, 24'h5F4F3D, 5'b00000};
        tbl[11] = '{24'h8899AA, 24'h8899A8, 8,  1'b1, 25, 24'h8899AA, 24'h8899A8, 24'h776655, 24'h776657, 5'b00000};
        tbl[12] = '{24'hFFFF00, 24'hFFFF01, 18, 1'b1, 35, 24'hFFFF00, 24'hFFFF01, 24'h0000FF, 24'h0000FE, 5'b00000};
        tbl[13] = '{24'h111111, 24'h222222, 19, 1'b1, 22, 24'hFFFF00, 24'hFFFF01, 24'h0000FF, 24'h0000FE, 5'b00010};
        tbl[14] = '{24'h333333, 24'h444444, 2,  1'b0, 22, 24'hFFFF00, 24'hFFFF01, 24'h0000FF, 24'h0000FE, 5'b00010};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ring_en", ring_en, 2'b00);
        chk("rst_sel", sel, 3'b000);
        chk("rst_trig", trig, 1'b0);
        chk("rst_count0", count0, 24'h0);
        chk("rst_count1", count1, 24'h0);
        chk("rst_ticks0", ticks0, 24'h0);
        chk("rst_flags", flags_now(), 5'b0);
        @(negedge clk);
        nrst = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven measurements
        for (int i = 0; i < NV; i++) begin
            m_c0 = tbl[i].c0;
            m_c1 = tbl[i].c1;
            fire_delay = tbl[i].delay;
            fire_en = tbl[i].en;
            e = '{tbl[i].ec0, tbl[i].ec1, tbl[i].et0, tbl[i].et1, tbl[i].flags, tbl[i].lat, 2};
            run_meas(e, 0);
            repeat (3) @(negedge clk);
        end

        // Fired flag already set in ARM: stale, no trigger, counts held
        force_fired = 1'b1;
        m_c0 = 24'h555555; m_c1 = 24'h666666;
        e = '{24'hFFFF00, 24'hFFFF01, 24'h0000FF, 24'h0000FE, 5'b00001, 1, 0};
        run_meas(e, 0);
        force_fired = 1'b0;
        repeat (3) @(negedge clk);

        // start and abort together in IDLE: abort wins
        dc0 = done_cnt;
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; abort = 1'b0;
        chk("start_abort_busy", busy, 1'b0);
        chk("start_abort_ring_en", ring_en, 2'b00);
        repeat (30) @(posedge clk);
        #1;
        chk("start_abort_no_done", done_cnt - dc0, 0);

        // Second start while busy is ignored
        m_c0 = 24'hFFFF00; m_c1 = 24'hFFFF02; fire_delay = 3; fire_en = 1'b1;
        dc0 = done_cnt;
        e = '{24'hFFFF00, 24'hFFFF02, 24'h0000FF, 24'h0000FD, 5'b00000, 20, 2};
        run_meas(e, 5);
        repeat (30) @(posedge clk);
        #1;
        chk("restart_single_done", done_cnt - dc0, 1);

        // Abort during READ
        m_c0 = 24'h111111; m_c1 = 24'h222222; fire_delay = 2;
        dc0 = done_cnt;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_ring_en", ring_en, 2'b00);
        chk("abort_trig", trig, 1'b0);
        chk("abort_sel", sel, 3'b000);
        repeat (30) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt - dc0, 0);
        chk("abort_count0", count0, 24'hFFFF00);
        chk("abort_count1", count1, 24'hFFFF02);
        chk("abort_ticks1", ticks1, 24'h0000FD);

        // Asynchronous reset during TRIG
        dc0 = done_cnt;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("trig_before_rst", trig, 1'b1);
        #2;
        nrst = 1'b0;
        #1;
        chk("arst_ring_en", ring_en, 2'b00);
        chk("arst_trig", trig, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_count0", count0, 24'h0);
        @(negedge clk);
        nrst = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("arst_no_done", done_cnt - dc0, 0);

        // Normal measurement after reset recovery
        m_c0 = 24'hA0B0C0; m_c1 = 24'hA0B0C2; fire_delay = 1; fire_en = 1'b1;
        e = '{24'hA0B0C0, 24'hA0B0C2, 24'h5F4F3F, 24'h5F4F3D, 5'b00000, 20, 2};
        run_meas(e, 0);

        chk("scoreboard_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
